// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: owns the system port of the 80x25 text memory and shares it
// between a host word-access requester and a clear/scroll-up engine.
//
// Ports:
//   sys_clk, sys_rst_n        clock, async active-low reset
//   host_req/we/a/dw          host request (level, held until host_ack)
//   host_ack, host_dr         one-cycle completion pulse, read data
//   cmd_clear, cmd_scroll     engine start pulses
//   fill_word                 fill value, sampled when a command is accepted
//   busy, done                engine running, one-cycle finish pulse
//   mem_a/we/dw, mem_dr       text memory port (read data one cycle late)
//
// state   | meaning
// IDLE    | port idle; accepts commands, then host requests
// H_ISSUE | host access presented on the memory port (grant cycle)
// H_WAIT  | memory read data returning
// H_ACK   | host_ack high; host_req ignored; resume engine or go idle
// CLR_WR  | clear write of fill word at r_idx
// SCR_RD  | scroll read of cell r_idx + COLS
// SCR_CAP | read data captured straight into mem_dw
// SCR_WR  | scroll write of captured word to r_idx
// FILL_WR | fill write of last row at r_idx
module vga_text_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 25,
  parameter int AW   = 11
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_a,
  input  logic [15:0]   host_dw,
  output logic          host_ack,
  output logic [15:0]   host_dr,
  input  logic          cmd_clear,
  input  logic          cmd_scroll,
  input  logic [15:0]   fill_word,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [15:0]   mem_dw,
  input  logic [15:0]   mem_dr
);

  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [AW-1:0] LAST_CELL = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] LAST_COPY = AW'(COLS * (ROWS - 1) - 1);

  typedef enum logic [3:0] {
    IDLE, H_ISSUE, H_WAIT, H_ACK, CLR_WR, SCR_RD, SCR_CAP, SCR_WR, FILL_WR
  } state_t;

  state_t        r_state;
  state_t        r_ret;     // where to go after a host access
  logic [AW-1:0] r_idx;
  logic [15:0]   r_fill;
  logic          r_hwe;

  state_t        w_nxt_st;
  state_t        w_tgt_st;
  logic [AW-1:0] w_nxt_idx;
  logic [AW-1:0] w_tgt_idx;
  logic [AW-1:0] w_tgt_a;
  logic          w_tgt_we;
  logic          w_last;

  // Next engine step after a write, and the step actually launched: either
  // straight after the write or after an interleaved host access (H_ACK).
  always_comb begin
    w_nxt_idx = r_idx + AW'(1);
    case (r_state)
      CLR_WR:  w_nxt_st = CLR_WR;
      FILL_WR: w_nxt_st = FILL_WR;
      SCR_WR:  w_nxt_st = (r_idx == LAST_COPY) ? FILL_WR : SCR_RD;
      default: w_nxt_st = SCR_RD;
    endcase
    w_tgt_st  = (r_state == H_ACK) ? r_ret : w_nxt_st;
    w_tgt_idx = (r_state == H_ACK) ? r_idx : w_nxt_idx;
    w_tgt_we  = (w_tgt_st != SCR_RD);
    w_tgt_a   = w_tgt_we ? w_tgt_idx : w_tgt_idx + COLS_A;
    w_last    = ((r_state == CLR_WR) || (r_state == FILL_WR)) && (r_idx == LAST_CELL);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= IDLE;
      r_ret    <= IDLE;
      r_idx    <= '0;
      r_fill   <= '0;
      r_hwe    <= 1'b0;
      mem_a    <= '0;
      mem_we   <= 1'b0;
      mem_dw   <= '0;
      host_ack <= 1'b0;
      host_dr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        IDLE: begin
          mem_we <= 1'b0;
          if (cmd_clear) begin
            r_fill  <= fill_word;
            r_idx   <= '0;
            mem_a   <= '0;
            mem_we  <= 1'b1;
            mem_dw  <= fill_word;
            busy    <= 1'b1;
            r_state <= CLR_WR;
          end else if (cmd_scroll) begin
            r_fill  <= fill_word;
            r_idx   <= '0;
            mem_a   <= COLS_A;
            busy    <= 1'b1;
            r_state <= SCR_RD;
          end else if (host_req) begin
            mem_a   <= host_a;
            mem_we  <= host_we;
            mem_dw  <= host_dw;
            r_hwe   <= host_we;
            r_ret   <= IDLE;
            r_state <= H_ISSUE;
          end
        end
        H_ISSUE: begin
          mem_we  <= 1'b0;
          r_state <= H_WAIT;
        end
        H_WAIT: begin
          host_ack <= 1'b1;
          if (!r_hwe) host_dr <= mem_dr;
          r_state  <= H_ACK;
        end
        H_ACK: begin
          if (r_ret == IDLE) begin
            r_state <= IDLE;
          end else begin
            r_state <= r_ret;
            mem_a   <= w_tgt_a;
            mem_we  <= w_tgt_we;
            mem_dw  <= r_fill;
          end
        end
        SCR_RD: r_state <= SCR_CAP;
        SCR_CAP: begin
          mem_a   <= r_idx;
          mem_we  <= 1'b1;
          mem_dw  <= mem_dr;
          r_state <= SCR_WR;
        end
        CLR_WR, SCR_WR, FILL_WR: begin
          if (w_last) begin
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_idx <= w_nxt_idx;
            // At most one host access per engine word keeps the engine moving.
            if (host_req) begin
              mem_a   <= host_a;
              mem_we  <= host_we;
              mem_dw  <= host_dw;
              r_hwe   <= host_we;
              r_ret   <= w_nxt_st;
              r_state <= H_ISSUE;
            end else begin
              r_state <= w_nxt_st;
              mem_a   <= w_tgt_a;
              mem_we  <= w_tgt_we;
              mem_dw  <= r_fill;
            end
          end
        end
        default: begin
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Bench for vga_text_ctrl: directed host accesses, clear, scroll (with and
// without a held host request), command collision and mid-scroll reset,
// against a small synchronous text-memory model.
module tb_vga_text_ctrl;
  localparam int AW = 11;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_a = '0;
  logic [15:0]   host_dw = '0;
  logic          host_ack;
  logic [15:0]   host_dr;
  logic          cmd_clear = 1'b0;
  logic          cmd_scroll = 1'b0;
  logic [15:0]   fill_word = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [15:0]   mem_dw;
  logic [15:0]   mem_dr;

  vga_text_ctrl #(.COLS(80), .ROWS(25), .AW(AW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .host_req(host_req), .host_we(host_we), .host_a(host_a), .host_dw(host_dw),
    .host_ack(host_ack), .host_dr(host_dr),
    .cmd_clear(cmd_clear), .cmd_scroll(cmd_scroll), .fill_word(fill_word),
    .busy(busy), .done(done),
    .mem_a(mem_a), .mem_we(mem_we), .mem_dw(mem_dw), .mem_dr(mem_dr)
  );

  always #5 sys_clk = ~sys_clk;

  // Text memory model: write on the edge, read data one cycle after address.
  logic [15:0] mem [0:2047];
  logic        pre_req = 1'b0;
  always @(posedge sys_clk) begin
    if (pre_req) begin
      for (int k = 0; k < 2048; k++)
        mem[k] <= (k == 2000) ? 16'hBEEF : (k == 2001) ? 16'h1234 :
                  (k < 2000) ? 16'(k) : 16'h0000;
    end else if (mem_we) begin
      mem[mem_a] <= mem_dw;
    end
    mem_dr <= mem[mem_a];
  end

  // Cumulative activity counters; tests look at differences.
  int cyc, we_cnt, busy_cnt, done_cnt, ack_cnt, late_cnt, bad_dr, last_wr;
  always @(negedge sys_clk) begin
    cyc++;
    if (mem_we) we_cnt++;
    if (mem_we && busy) last_wr = cyc;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (host_ack && busy) begin
      ack_cnt++;
      if (cyc - last_wr > 5) late_cnt++;
      if (host_dr !== 16'h1234) bad_dr++;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload();
    pre_req = 1'b1;
    @(negedge sys_clk);
    pre_req = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic host_access(input logic we, input logic [AW-1:0] a, input logic [15:0] d,
                             output logic [15:0] rd, output int lat, output bit grant_ok);
    host_req = 1'b1; host_we = we; host_a = a; host_dw = d;
    lat = 0; rd = '0; grant_ok = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sys_clk);
      if (k == 1) grant_ok = (mem_a == a) && (mem_we == we);
      if (host_ack) begin
        lat = k;
        rd  = host_dr;
        break;
      end
    end
    host_req = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic run_engine(input logic clr, input logic scr, input logic [15:0] fill,
                            input bit hold, input int inject_at,
                            output int busy_d, output int done_d, output int ack_d,
                            output int late_d, output int bad_d);
    int b0, d0, a0, l0, x0;
    bit seen;
    b0 = busy_cnt; d0 = done_cnt; a0 = ack_cnt; l0 = late_cnt; x0 = bad_dr;
    cmd_clear = clr; cmd_scroll = scr; fill_word = fill;
    if (hold) begin
      host_req = 1'b1; host_we = 1'b0; host_a = 11'd2001;
    end
    seen = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge sys_clk);
      cmd_clear  = 1'b0;
      cmd_scroll = (k == inject_at);
      if (k == inject_at) fill_word = 16'h9999;
      if (done) begin
        seen = 1'b1;
        host_req = 1'b0;
      end
    end
    cmd_scroll = 1'b0;
    host_req   = 1'b0;
    chk("engine_done_seen", 64'(seen), 64'd1);
    repeat (5) @(negedge sys_clk);
    busy_d = busy_cnt - b0; done_d = done_cnt - d0; ack_d = ack_cnt - a0;
    late_d = late_cnt - l0; bad_d = bad_dr - x0;
  endtask

  task automatic chk_scroll(input string tag);
    int bad = 0;
    for (int k = 0; k < 1920; k++) if (mem[k] !== 16'(k + 80)) bad++;
    for (int k = 1920; k < 2000; k++) if (mem[k] !== 16'h0000) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  task automatic chk_fill(input string tag, input logic [15:0] f);
    int bad = 0;
    for (int k = 0; k < 2000; k++) if (mem[k] !== f) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  logic [15:0] rd;
  int lat, w0, d0, bd, dd, ad, ld, xd;
  bit gok;
  bit found;

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("reset_outputs", 64'({mem_a, mem_we, mem_dw, host_ack, host_dr, busy, done}), 64'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    preload();

    // Host write then read back.
    w0 = we_cnt;
    host_access(1'b1, 11'd5, 16'h1F41, rd, lat, gok);
    chk("wr_grant", 64'(gok), 64'd1);
    chk("wr_latency", 64'(lat), 64'd3);
    chk("wr_we_pulses", 64'(we_cnt - w0), 64'd1);
    chk("wr_mem5", 64'(mem[5]), 64'h1F41);
    host_access(1'b0, 11'd5, 16'h0000, rd, lat, gok);
    chk("rd_grant", 64'(gok), 64'd1);
    chk("rd_latency", 64'(lat), 64'd3);
    chk("rd_data", 64'(rd), 64'h1F41);
    chk("rd_no_write", 64'(we_cnt - w0), 64'd1);

    // Clear.
    run_engine(1'b1, 1'b0, 16'h0720, 1'b0, -1, bd, dd, ad, ld, xd);
    chk("clr_busy_cycles", 64'(bd), 64'd2000);
    chk("clr_done_pulses", 64'(dd), 64'd1);
    chk_fill("clr_cells", 16'h0720);
    chk("clr_cell2000", 64'(mem[2000]), 64'hBEEF);
    host_access(1'b0, 11'd1999, 16'h0000, rd, lat, gok);
    chk("clr_rd1999", 64'(rd), 64'h0720);
    host_access(1'b0, 11'd2000, 16'h0000, rd, lat, gok);
    chk("rd_addr2000", 64'(rd), 64'hBEEF);

    // Scroll, uncontended.
    preload();
    run_engine(1'b0, 1'b1, 16'h0000, 1'b0, -1, bd, dd, ad, ld, xd);
    chk("scr_busy_cycles", 64'(bd), 64'd5840);
    chk("scr_done_pulses", 64'(dd), 64'd1);
    chk_scroll("scr_cells");
    chk("scr_cell0", 64'(mem[0]), 64'd80);
    chk("scr_cell1919", 64'(mem[1919]), 64'd1999);

    // Scroll with host_req held (asserted together with the command).
    preload();
    run_engine(1'b0, 1'b1, 16'h0000, 1'b1, -1, bd, dd, ad, ld, xd);
    chk("hold_busy_cycles", 64'(bd), 64'(5840 + 3 * 1999));
    chk("hold_acks", 64'(ad), 64'd1999);
    chk("hold_late_acks", 64'(ld), 64'd0);
    chk("hold_bad_rdata", 64'(xd), 64'd0);
    chk("hold_done_pulses", 64'(dd), 64'd1);
    chk_scroll("hold_cells");

    // Clear + scroll together, then a scroll while busy: only the clear runs.
    preload();
    run_engine(1'b1, 1'b1, 16'h0055, 1'b0, 10, bd, dd, ad, ld, xd);
    chk("coll_busy_cycles", 64'(bd), 64'd2000);
    chk("coll_done_pulses", 64'(dd), 64'd1);
    chk_fill("coll_cells", 16'h0055);
    chk("coll_cell2000", 64'(mem[2000]), 64'hBEEF);

    // Reset at scroll word 500.
    preload();
    d0 = done_cnt;
    cmd_scroll = 1'b1; fill_word = 16'h0000;
    @(negedge sys_clk);
    cmd_scroll = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 5000 && !found; k++) begin
      @(negedge sys_clk);
      if (mem_we && mem_a == 11'd500) found = 1'b1;
    end
    chk("rst_word500_reached", 64'(found), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_outputs", 64'({mem_a, mem_we, mem_dw, host_ack, host_dr, busy, done}), 64'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    chk("rst_idle_busy", 64'(busy), 64'd0);
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_cell499", 64'(mem[499]), 64'd579);
    chk("rst_cell500", 64'(mem[500]), 64'd500);
    host_access(1'b1, 11'd3, 16'hABCD, rd, lat, gok);
    chk("rst_wr_latency", 64'(lat), 64'd3);
    host_access(1'b0, 11'd3, 16'h0000, rd, lat, gok);
    chk("rst_rd_data", 64'(rd), 64'hABCD);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_text_ctrl.md
Name: vga_text_ctrl

Overview:
- Owns the system port of the 80x25 text memory.
- Shares that port between a host word-access requester and a hardware clear/scroll engine.
- Clear: fills all 2000 cells with a fill word. Scroll: moves rows 1..24 up one row, then fills row 24.
- Sits between the CSR/bus glue and the text memory. The VGA scan-out port is not touched.

Parameters:
- COLS, 80, characters per row.
- ROWS, 25, rows per screen; cells = COLS*ROWS = 2000, linear word addresses 0..1999.
- AW, 11, text memory word-address width.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- host_req  in  1  host access request; level, held until host_ack.
- host_we  in  1  1 = write, 0 = read; stable while host_req.
- host_a  in  AW  host word address; stable while host_req.
- host_dw  in  16  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_dr  out  16  read data; valid in the host_ack cycle.
- cmd_clear  in  1  pulse: start clear.
- cmd_scroll  in  1  pulse: start scroll-up.
- fill_word  in  16  char/attr fill value; sampled when a command is accepted.
- busy  out  1  engine running.
- done  out  1  one-cycle pulse when the engine finishes.
- mem_a  out  AW  memory address (to sys_a).
- mem_we  out  1  memory write enable.
- mem_dw  out  16  memory write data.
- mem_dr  in  16  memory read data; valid the cycle after mem_a is presented with mem_we=0.

Behaviour:
- Reset: asynchronous, active-low, on sys_rst_n.
  - All outputs go to 0 (mem_a, mem_we, mem_dw, host_ack, host_dr, busy, done). FSM goes to IDLE.
  - Reset asserted mid-operation aborts it. Memory is left partially updated; no done pulse.
- Outputs: all registered. mem_we is high for exactly one cycle per write.
- FSM states: IDLE, H_ISSUE, H_WAIT, H_ACK, CLR_WR, SCR_RD, SCR_CAP, SCR_WR, FILL_WR.
- Host access, 3 cycles, from grant cycle G:
  - G: mem_a=host_a; mem_we=host_we, mem_dw=host_dw.
  - G+1: mem_dr arrives.
  - G+2: host_ack=1; host_dr = mem_dr captured at end of G+1 (reads only; host_dr holds for writes).
  - host_req is ignored in the ack cycle. A request seen in the cycle after ack is a new request.
  - host_a >= 2000: access performed as-is, no checking.
- Command acceptance:
  - Only in IDLE with no host access in flight. busy rises the next cycle.
  - Commands arriving while busy or during a host access are dropped, not queued.
  - cmd_clear and cmd_scroll in the same cycle: clear wins.
  - host_req and a command in the same IDLE cycle: the command wins; the host is served at the first interleave slot.
- Clear: CLR_WR writes fill_word to addresses 0..1999, one per cycle.
- Scroll: for i = 0..1919, three cycles per word:
  - SCR_RD: mem_a=i+COLS.
  - SCR_CAP: capture mem_dr.
  - SCR_WR: mem_a=i, mem_we=1, mem_dw=captured word.
  - Then FILL_WR writes fill_word to 1920..1999.
- Interleave: after every engine write (CLR_WR, SCR_WR, FILL_WR), a pending host_req gets one host access (H_ISSUE..H_ACK), then the engine resumes at the next address.
  - Worst-case host latency: 3 cycles to grant, ack 2 cycles after grant.
  - Engine progress is guaranteed: at most one host access per engine word.
- Completion: done=1 and busy=0 in the cycle after the last engine write cycle (address 1999). Back to IDLE.
- Counters: 11-bit word index. Terminal compare at 1919 (copy) and 1999 (fill/clear); no wrap past 1999.
- Uncontended cycle counts: clear 2000 port cycles; scroll 5760 + 80 = 5840.

Test Plan:
- Host write 0x1F41 @0x005, then read @0x005 -> read ack exactly 2 cycles after grant, host_dr=0x1F41; mem_we pulses once for the write only.
- cmd_clear, fill_word=0x0720 -> busy for 2000 cycles; done pulse once; every address 0..1999 reads 0x0720; address 2000 is unchanged.
- Preload cell k = k; cmd_scroll, fill=0x0000 -> cell i = i+80 for i<1920; cells 1920..1999 = 0; done after 5840 busy cycles.
- host_req held throughout a scroll -> each ack lands within 5 cycles of the previous engine write; scroll result still correct; total busy = 5840 + 3 × host accesses.
- cmd_clear and cmd_scroll in the same cycle, then a second cmd_scroll while busy -> only the clear executes; exactly one done pulse.
- sys_rst_n low at scroll word 500 -> outputs 0 immediately; after release: idle, host access works, no done pulse.
